// File: rtl/csa_pkg.sv
// Shared types and helpers for the block-serial carry-select adder/subtractor.
//   state_e   : controller states (idle, slice processing, result hold)
//   idx_width : width of the slice index, never below one bit
package csa_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // A single-slice configuration still needs a one-bit index register.
    function automatic int unsigned idx_width(input int unsigned nblk);
        if (nblk > 1) begin
            return $clog2(nblk);
        end
        return 1;
    endfunction

endpackage

// File: rtl/csa_seq_addsub_if.sv
// Operand/result bus of csa_seq_addsub.
//   in_valid/in_ready   : operand handshake (a, b, sub, c_in)
//   out_valid/out_ready : result handshake (s, c_out, ovf)
//   master : operand producer and result consumer side
//   slave  : the arithmetic block
interface csa_seq_addsub_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             ovf;

    modport master (
        output in_valid, a, b, sub, c_in, out_ready,
        input  in_ready, out_valid, s, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, c_in, out_ready,
        output in_ready, out_valid, s, c_out, ovf
    );

endinterface

// File: rtl/csa_dual_block.sv
// One carry-select slice: adds a BLOCK-bit slice pair under both carry-in
// hypotheses so the caller only has to pick one result with the real carry.
//   a_i, b_i         : operand slices
//   sum0_o, cout0_o  : result assuming carry-in 0
//   sum1_o, cout1_o  : result assuming carry-in 1
module csa_dual_block #(
    parameter int unsigned BLOCK = 4
) (
    input  logic [BLOCK-1:0] a_i,
    input  logic [BLOCK-1:0] b_i,
    output logic [BLOCK-1:0] sum0_o,
    output logic [BLOCK-1:0] sum1_o,
    output logic             cout0_o,
    output logic             cout1_o
);

    localparam logic [BLOCK:0] One = {{BLOCK{1'b0}}, 1'b1};

    logic [BLOCK:0] sum_c0;
    logic [BLOCK:0] sum_c1;

    assign sum_c0 = {1'b0, a_i} + {1'b0, b_i};
    assign sum_c1 = {1'b0, a_i} + {1'b0, b_i} + One;

    assign {cout0_o, sum0_o} = sum_c0;
    assign {cout1_o, sum1_o} = sum_c1;

endmodule

// File: rtl/csa_seq_addsub.sv
// Block-serial carry-select adder/subtractor.
// Operands are captured once on acceptance, then one BLOCK-bit slice is
// resolved per cycle (LSB slice first) by a single time-multiplexed dual
// slice adder; the registered carry picks the matching hypothesis.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of csa_seq_addsub_if (operands in, result out)
// Result: {c_out, s} = a + beff + cin_eff, with beff/cin_eff inverted for
// subtract, so c_out is NOT-borrow when subtracting; ovf is signed overflow.
module csa_seq_addsub
    import csa_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned BLOCK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    csa_seq_addsub_if.slave   bus
);

    localparam int unsigned NBLK = WIDTH / BLOCK;
    localparam int unsigned IW   = idx_width(NBLK);
    localparam logic [IW-1:0] LastIdx = IW'(NBLK - 1);

    if ((BLOCK == 0) || ((WIDTH % BLOCK) != 0)) begin : gen_width_check
        $error("csa_seq_addsub: WIDTH must be a non-zero multiple of BLOCK");
    end

    state_e state_q, state_d;

    // Operands and result held as slice arrays so the slice index selects directly.
    logic [NBLK-1:0][BLOCK-1:0] a_q, a_d;
    logic [NBLK-1:0][BLOCK-1:0] beff_q, beff_d;
    logic [NBLK-1:0][BLOCK-1:0] s_q, s_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic                       carry_q, carry_d;
    logic                       c_out_q, c_out_d;
    logic                       ovf_q, ovf_d;

    logic             in_ready;
    logic             out_valid;
    logic             last_blk;
    logic [BLOCK-1:0] sum0, sum1, sum_sel;
    logic             cout0, cout1, cout_sel;

    csa_dual_block #(
        .BLOCK (BLOCK)
    ) u_dual_block (
        .a_i     (a_q[idx_q]),
        .b_i     (beff_q[idx_q]),
        .sum0_o  (sum0),
        .sum1_o  (sum1),
        .cout0_o (cout0),
        .cout1_o (cout1)
    );

    assign sum_sel  = carry_q ? sum1 : sum0;
    assign cout_sel = carry_q ? cout1 : cout0;
    assign last_blk = (idx_q == LastIdx);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.in_valid) state_d = StRun;
            StRun:  if (last_blk) state_d = StDone;
            StDone: if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle:  in_ready = 1'b1;
            StRun:   ;
            StDone:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath next state
    always_comb begin
        a_d     = a_q;
        beff_d  = beff_q;
        s_d     = s_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        if (state_q == StIdle) begin
            if (bus.in_valid) begin
                a_d     = bus.a;
                beff_d  = bus.sub ? ~bus.b : bus.b;
                carry_d = bus.sub ^ bus.c_in;
                idx_d   = '0;
            end
        end else if (state_q == StRun) begin
            s_d[idx_q] = sum_sel;
            carry_d    = cout_sel;
            idx_d      = idx_q + IW'(1);
            if (last_blk) begin
                idx_d   = '0;
                c_out_d = cout_sel;
                // Operand signs agree but the result sign differs.
                ovf_d   = (a_q[NBLK-1][BLOCK-1] == beff_q[NBLK-1][BLOCK-1]) &&
                          (sum_sel[BLOCK-1] != a_q[NBLK-1][BLOCK-1]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            beff_q  <= '0;
            s_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            beff_q  <= beff_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.s         = s_q;
    assign bus.c_out     = c_out_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_csa_seq_addsub.sv
// Scoreboard bench for csa_seq_addsub: expected results are queued when an
// operation is offered and compared when the result handshake completes.
module tb_csa_seq_addsub;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned BLOCK = 4;
    localparam int unsigned NBLK  = WIDTH / BLOCK;
    localparam int unsigned NRAND = 10000;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             v;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    csa_seq_addsub_if #(.WIDTH(WIDTH)) bus ();

    csa_seq_addsub #(
        .WIDTH (WIDTH),
        .BLOCK (BLOCK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    res_t sb_q[$];
    bit   rand_ready  = 1'b0;
    logic ready_force = 1'b1;
    logic rnd_ready   = 1'b1;

    assign bus.out_ready = rand_ready ? rnd_ready : ready_force;

    always begin
        @(posedge clk);
        #1;
        rnd_ready = ($urandom_range(7) != 0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic sub, input logic cin);
        res_t             r;
        logic [WIDTH-1:0] beff;
        logic             ce;
        logic [WIDTH:0]   t;
        beff = sub ? ~b : b;
        ce   = sub ? ~cin : cin;
        t    = {1'b0, a} + {1'b0, beff} + {{WIDTH{1'b0}}, ce};
        r.s  = t[WIDTH-1:0];
        r.c  = t[WIDTH];
        r.v  = (a[WIDTH-1] == beff[WIDTH-1]) && (r.s[WIDTH-1] != a[WIDTH-1]);
        return r;
    endfunction

    // Result monitor: the handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_result", 32'd1, 32'd0);
            end else begin
                res_t e;
                e = sb_q.pop_front();
                check("s", 32'(bus.s), 32'(e.s));
                check("c_out", 32'(bus.c_out), 32'(e.c));
                check("ovf", 32'(bus.ovf), 32'(e.v));
            end
        end
    end

    // Offer one operation and return just after the accepting edge.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic sub, input logic cin, input bit track);
        logic rdy;
        int   k;
        if (track) sb_q.push_back(model(a, b, sub, cin));
        bus.a        = a;
        bus.b        = b;
        bus.sub      = sub;
        bus.c_in     = cin;
        bus.in_valid = 1'b1;
        for (k = 0; k < 200; k++) begin
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
        end
        if (k == 200) check("accept_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
        // Scramble inputs; the operation must be unaffected.
        bus.a    = WIDTH'($urandom);
        bus.b    = WIDTH'($urandom);
        bus.sub  = 1'($urandom);
        bus.c_in = 1'($urandom);
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 2000; k++) begin
            if (sb_q.size() == 0 && !bus.out_valid) break;
            @(posedge clk);
            #1;
        end
        if (k == 2000) check("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.sub      = 1'b0;
        bus.c_in     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_s", 32'(bus.s), 32'd0);
        check("rst_c_out", 32'(bus.c_out), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Carry ripples through every slice; also measure latency.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        n = 1;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 32'(n), 32'(NBLK + 1));
        drain();

        send(16'h0005, 16'h0007, 1'b1, 1'b0, 1'b1);
        send(16'h0007, 16'h0005, 1'b1, 1'b0, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        send(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1);
        drain();

        // Backpressure in DONE with a competing request.
        ready_force = 1'b0;
        send(16'h00FF, 16'h0F01, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_s", 32'(bus.s), 32'h1000);
            check("bp_c_out", 32'(bus.c_out), 32'd0);
            check("bp_ovf", 32'(bus.ovf), 32'd0);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            bus.in_valid = 1'b1;
            bus.a        = 16'hAAAA;
            bus.b        = 16'h5555;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        ready_force  = 1'b1;
        @(posedge clk);
        #1;
        check("bp_rel_out_valid", 32'(bus.out_valid), 32'd0);
        check("bp_rel_in_ready", 32'(bus.in_ready), 32'd1);
        check("bp_rel_s_kept", 32'(bus.s), 32'h1000);
        drain();

        // Reset two cycles into RUN discards the operation.
        send(16'hAAAA, 16'h5555, 1'b0, 1'b1, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_s", 32'(bus.s), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(16'h1234, 16'h4321, 1'b0, 1'b1, 1'b1);
        drain();
        check("post_rst_s", 32'(bus.s), 32'h5556);
        check("post_rst_c_out", 32'(bus.c_out), 32'd0);

        // Random regression with consumer stalls.
        rand_ready = 1'b1;
        for (int i = 0; i < NRAND; i++) begin
            send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        end
        drain();
        rand_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
